// File: rtl/rob.sv
// Reorder buffer: 16-entry circular buffer that retires results in program order.
// Latency: allocation, CDB writes and commit all take effect at the next edge; lookup and commit outputs are combinational.
// Backpressure: rb_full from registered count stalls upstream; inst_valid while full is dropped.
//
// Ports:
//   clk, rst               clock and synchronous active-low reset
//   inst_valid/type/dest   allocation request; rb_tail is the tag it receives, rb_full blocks it
//   rd_rb_tag1/2           operand lookup tags -> rb_tag*_rdy / rb_tag*_value
//   cdb_valid/tag/data     result broadcast; cdb_mispredict marks a mispredicted branch
//   commit_*               in-order retirement of the head entry
//   mispredict/redirect_pc flush request raised while a mispredicted branch sits at the head
module rob (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [2:0]  inst_type,
  input  logic [6:0]  inst_dest,
  output logic [3:0]  rb_tail,
  output logic        rb_full,
  input  logic [3:0]  rd_rb_tag1,
  input  logic [3:0]  rd_rb_tag2,
  output logic        rb_tag1_rdy,
  output logic        rb_tag2_rdy,
  output logic [31:0] rb_tag1_value,
  output logic [31:0] rb_tag2_value,
  input  logic        cdb_valid,
  input  logic [3:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  input  logic        cdb_mispredict,
  output logic        commit_reg_valid,
  output logic        commit_store_valid,
  output logic [6:0]  commit_dest,
  output logic [31:0] commit_value,
  output logic [3:0]  commit_tag,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int RB_DEPTH = 16;

  localparam logic [2:0] TYPE_ALU    = 3'd0;
  localparam logic [2:0] TYPE_LOAD   = 3'd1;
  localparam logic [2:0] TYPE_STORE  = 3'd2;

  typedef struct packed {
    logic        bsy;
    logic        rdy;
    logic [2:0]  itype;
    logic [6:0]  dest;
    logic [31:0] value;
    logic        mispred;
  } entry_t;

  entry_t      ent_q [RB_DEPTH];
  entry_t      ent_d [RB_DEPTH];
  logic [3:0]  head_q, head_d;
  logic [3:0]  tail_q, tail_d;
  logic [4:0]  count_q, count_d;

  logic head_done;
  logic commit_fire;
  logic flush;
  logic head_is_reg;
  logic head_is_store;
  logic head_writes;
  logic alloc;
  logic cdb_hit;

  // ---------------------------------------------------------------------------
  // Head evaluation: a finished head either retires or, if it is a mispredicted
  // branch, raises the flush instead of committing.
  // ---------------------------------------------------------------------------
  assign head_done     = ent_q[head_q].bsy & ent_q[head_q].rdy;
  assign commit_fire   = head_done & ~ent_q[head_q].mispred;
  assign flush         = head_done &  ent_q[head_q].mispred;
  assign head_is_reg   = (ent_q[head_q].itype == TYPE_ALU) ||
                         (ent_q[head_q].itype == TYPE_LOAD);
  assign head_is_store = (ent_q[head_q].itype == TYPE_STORE);

  assign commit_reg_valid   = commit_fire & head_is_reg;
  assign commit_store_valid = commit_fire & head_is_store;

  // Branches retire silently, so their payload is kept off the commit bus.
  assign head_writes  = commit_reg_valid | commit_store_valid;
  assign commit_dest  = head_writes ? ent_q[head_q].dest  : 7'd0;
  assign commit_value = head_writes ? ent_q[head_q].value : 32'd0;
  assign commit_tag   = head_writes ? head_q              : 4'd0;

  assign mispredict  = flush;
  assign redirect_pc = flush ? ent_q[head_q].value : 32'd0;

  // ---------------------------------------------------------------------------
  // Status and lookup: read straight from the registered array. A result on
  // the CDB this cycle is not forwarded; it becomes visible after the edge.
  // ---------------------------------------------------------------------------
  assign rb_tail = tail_q;
  assign rb_full = (count_q == 5'd16);

  assign rb_tag1_rdy   = ent_q[rd_rb_tag1].bsy & ent_q[rd_rb_tag1].rdy;
  assign rb_tag2_rdy   = ent_q[rd_rb_tag2].bsy & ent_q[rd_rb_tag2].rdy;
  assign rb_tag1_value = ent_q[rd_rb_tag1].bsy ? ent_q[rd_rb_tag1].value : 32'd0;
  assign rb_tag2_value = ent_q[rd_rb_tag2].bsy ? ent_q[rd_rb_tag2].value : 32'd0;

  // Full is judged on the registered count, so a commit in the same cycle
  // does not open a slot until the following cycle.
  assign alloc   = inst_valid & ~rb_full;
  assign cdb_hit = cdb_valid & ent_q[cdb_tag].bsy;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < RB_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      // Everything younger than the branch is wrong-path; the branch itself
      // is discarded too. Same-cycle allocation and CDB writes are dropped.
      for (int i = 0; i < RB_DEPTH; i++) begin
        ent_d[i] = '0;
      end
      head_d  = 4'd0;
      tail_d  = 4'd0;
      count_d = 5'd0;
    end else begin
      // When not full the tail slot is idle, so it never collides with the
      // head being cleared or with a CDB write (which needs a busy entry).
      if (alloc) begin
        ent_d[tail_q].bsy     = 1'b1;
        ent_d[tail_q].rdy     = 1'b0;
        ent_d[tail_q].itype   = inst_type;
        ent_d[tail_q].dest    = inst_dest;
        ent_d[tail_q].value   = 32'd0;
        ent_d[tail_q].mispred = 1'b0;
        tail_d                = tail_q + 4'd1;
      end

      if (cdb_hit) begin
        ent_d[cdb_tag].rdy     = 1'b1;
        ent_d[cdb_tag].value   = cdb_data;
        ent_d[cdb_tag].mispred = cdb_mispredict;
      end

      // Applied last so a retiring head is cleared even if the CDB rewrote it.
      if (commit_fire) begin
        ent_d[head_q] = '0;
        head_d        = head_q + 4'd1;
      end

      case ({alloc, commit_fire})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers; reset dominates every other update.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RB_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= 4'd0;
      tail_q  <= 4'd0;
      count_q <= 5'd0;
    end else begin
      for (int i = 0; i < RB_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Randomized scoreboard bench for the reorder buffer.
// Reference model: in-flight instructions kept as an ordered queue; tags assigned sequentially mod 16.
// Expected status and retirement events are queued by the stimulus process and checked by a monitor.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [2:0]  inst_type;
  logic [6:0]  inst_dest;
  logic [3:0]  rb_tail;
  logic        rb_full;
  logic [3:0]  rd_rb_tag1, rd_rb_tag2;
  logic        rb_tag1_rdy, rb_tag2_rdy;
  logic [31:0] rb_tag1_value, rb_tag2_value;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_mispredict;
  logic        commit_reg_valid, commit_store_valid;
  logic [6:0]  commit_dest;
  logic [31:0] commit_value;
  logic [3:0]  commit_tag;
  logic        mispredict;
  logic [31:0] redirect_pc;

  rob dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_type(inst_type), .inst_dest(inst_dest),
    .rb_tail(rb_tail), .rb_full(rb_full),
    .rd_rb_tag1(rd_rb_tag1), .rd_rb_tag2(rd_rb_tag2),
    .rb_tag1_rdy(rb_tag1_rdy), .rb_tag2_rdy(rb_tag2_rdy),
    .rb_tag1_value(rb_tag1_value), .rb_tag2_value(rb_tag2_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict),
    .commit_reg_valid(commit_reg_valid), .commit_store_valid(commit_store_valid),
    .commit_dest(commit_dest), .commit_value(commit_value), .commit_tag(commit_tag),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  localparam int NCYC = 4000;

  typedef struct {
    logic [3:0]  tag;
    logic [2:0]  typ;
    logic [6:0]  dest;
    logic        rdy;
    logic [31:0] val;
    logic        mp;
  } ment_t;

  typedef struct {
    int          cyc;
    logic        fl;
    logic        rg;
    logic        st;
    logic [6:0]  dest;
    logic [31:0] val;
    logic [3:0]  tag;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [3:0]  tail;
    logic        full;
    logic        r1;
    logic [31:0] v1;
    logic        r2;
    logic [31:0] v2;
  } st_t;

  ment_t      mq[$];
  ev_t        evq[$];
  st_t        stq[$];
  logic [3:0] next_tag = 4'd0;
  int         n_pass = 0;
  int         n_total = 0;
  int         mon_cyc = 0;
  int         n_flush = 0;
  int         n_full = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, mon_cyc, act, req);
  endtask

  function automatic void look(input logic [3:0] t, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (mq[k]) begin
      if (mq[k].tag == t) begin
        r = mq[k].rdy;
        v = mq[k].val;
      end
    end
  endfunction

  function automatic logic [3:0] pick_tag();
    if (mq.size() > 0 && ($urandom % 2 == 0))
      return mq[$urandom_range(0, mq.size() - 1)].tag;
    return 4'($urandom % 16);
  endfunction

  // Stimulus + reference model
  initial begin
    rst = 1'b0; inst_valid = 1'b0; inst_type = 3'd0; inst_dest = 7'd0;
    rd_rb_tag1 = 4'd0; rd_rb_tag2 = 4'd0;
    cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_data = 32'd0; cdb_mispredict = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NCYC; i++) begin
      int      alloc_pct, cdb_pct;
      int      pend[$];
      st_t     s;
      ev_t     e;
      logic    do_commit, do_alloc, fl;
      ment_t   n;

      case ((i / 150) % 4)
        0:       begin alloc_pct = 90; cdb_pct = 20; end
        2:       begin alloc_pct = 10; cdb_pct = 90; end
        default: begin alloc_pct = 60; cdb_pct = 60; end
      endcase

      // Choose inputs for this cycle.
      rst        = (i < 2 || $urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      inst_valid = ($urandom_range(0, 99) < alloc_pct);
      inst_type  = 3'($urandom % 4);
      inst_dest  = 7'($urandom);
      rd_rb_tag1 = pick_tag();
      rd_rb_tag2 = pick_tag();
      cdb_valid  = ($urandom_range(0, 99) < cdb_pct);
      cdb_data   = $urandom;
      foreach (mq[k]) if (!mq[k].rdy) pend.push_back(k);
      if (pend.size() > 0 && ($urandom % 8 != 0)) begin
        int k;
        k = pend[$urandom_range(0, pend.size() - 1)];
        cdb_tag        = mq[k].tag;
        cdb_mispredict = (mq[k].typ == 3'd3) ? ($urandom % 10 == 0) : 1'b0;
      end else begin
        cdb_tag        = 4'($urandom % 16);
        cdb_mispredict = ($urandom % 32 == 0);
      end

      // Expected outputs this cycle, from the model state before the edge.
      s.cyc  = i;
      s.tail = next_tag;
      s.full = (mq.size() == 16);
      look(rd_rb_tag1, s.r1, s.v1);
      look(rd_rb_tag2, s.r2, s.v2);
      stq.push_back(s);
      if (s.full) n_full++;

      fl        = (mq.size() > 0) && mq[0].rdy && mq[0].mp;
      do_commit = (mq.size() > 0) && mq[0].rdy && !mq[0].mp;
      if (fl) begin
        e = '{cyc: i, fl: 1'b1, rg: 1'b0, st: 1'b0, dest: 7'd0, val: mq[0].val, tag: 4'd0};
        evq.push_back(e);
      end else if (do_commit && mq[0].typ != 3'd3) begin
        e = '{cyc: i, fl: 1'b0, rg: (mq[0].typ <= 3'd1), st: (mq[0].typ == 3'd2),
              dest: mq[0].dest, val: mq[0].val, tag: mq[0].tag};
        evq.push_back(e);
      end

      // Advance the model to the state after the edge.
      if (!rst || fl) begin
        if (fl && rst) n_flush++;
        mq.delete();
        next_tag = 4'd0;
      end else begin
        do_alloc = inst_valid && (mq.size() < 16);
        if (cdb_valid) begin
          foreach (mq[k]) begin
            if (mq[k].tag == cdb_tag) begin
              mq[k].rdy = 1'b1;
              mq[k].val = cdb_data;
              mq[k].mp  = cdb_mispredict;
            end
          end
        end
        if (do_commit) void'(mq.pop_front());
        if (do_alloc) begin
          n = '{tag: next_tag, typ: inst_type, dest: inst_dest, rdy: 1'b0, val: 32'd0, mp: 1'b0};
          mq.push_back(n);
          next_tag = next_tag + 4'd1;
        end
      end

      @(posedge clk); #1;
    end

    inst_valid = 1'b0;
    cdb_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("leftover_events", evq.size(), 0);
    $display("info: cycles with buffer full=%0d, flushes=%0d", n_full, n_flush);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Monitor: compares presented outputs against queued expectations.
  initial begin
    forever begin
      st_t  s;
      ev_t  e;
      logic pres;
      @(negedge clk);
      if (stq.size() == 0) continue;
      s = stq.pop_front();
      mon_cyc = s.cyc;
      chk("rb_tail", rb_tail, s.tail);
      chk("rb_full", rb_full, s.full);
      chk("tag1_rdy", rb_tag1_rdy, s.r1);
      chk("tag1_value", rb_tag1_value, s.v1);
      chk("tag2_rdy", rb_tag2_rdy, s.r2);
      chk("tag2_value", rb_tag2_value, s.v2);

      pres = commit_reg_valid | commit_store_valid | mispredict;
      if (evq.size() > 0 && evq[0].cyc == s.cyc) begin
        e = evq.pop_front();
        chk("commit_reg_valid", commit_reg_valid, e.rg);
        chk("commit_store_valid", commit_store_valid, e.st);
        chk("mispredict", mispredict, e.fl);
        chk("redirect_pc", redirect_pc, e.fl ? e.val : 32'd0);
        chk("commit_dest", commit_dest, e.fl ? 7'd0 : e.dest);
        chk("commit_value", commit_value, e.fl ? 32'd0 : e.val);
        chk("commit_tag", commit_tag, e.fl ? 4'd0 : e.tag);
      end else begin
        chk("unexpected_output", pres, 1'b0);
        chk("idle_commit_dest", commit_dest, 7'd0);
        chk("idle_commit_value", commit_value, 32'd0);
        chk("idle_commit_tag", commit_tag, 4'd0);
        chk("idle_redirect_pc", redirect_pc, 32'd0);
      end
    end
  end

endmodule
